// File: rtl/alu_rr_scheduler.sv
// Round-robin front end that shares one combinational 16-bit ALU among N_REQ requesters.
// Optional build macro ALU_SCHED_PRIO_EN makes requester 0 a fixed high-priority client.
module alu_rr_scheduler #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [N_REQ-1:0]     i_req_valid,
  output logic [N_REQ-1:0]     o_req_ready,
  input  logic [16*N_REQ-1:0]  i_req_a,
  input  logic [16*N_REQ-1:0]  i_req_b,
  input  logic [N_REQ-1:0]     i_req_cin,
  input  logic [3*N_REQ-1:0]   i_req_opc,
  output logic [15:0]          o_alu_a,
  output logic [15:0]          o_alu_b,
  output logic                 o_alu_cin,
  output logic [2:0]           o_alu_opc,
  input  logic [15:0]          i_alu_w,
  input  logic                 i_alu_f1,
  input  logic                 i_alu_f2,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [IDW-1:0]       o_rsp_id,
  output logic [15:0]          o_rsp_w,
  output logic                 o_rsp_f1,
  output logic                 o_rsp_f2
);

`ifdef ALU_SCHED_PRIO_EN
  localparam bit PRIO_EN = 1'b1;
`else
  localparam bit PRIO_EN = 1'b0;
`endif

  localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(N_REQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(N_REQ-1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  r_grant_id;
  logic [15:0]     r_alu_a;
  logic [15:0]     r_alu_b;
  logic            r_alu_cin;
  logic [2:0]      r_alu_opc;
  logic [IDW-1:0]  r_rsp_id;
  logic [15:0]     r_rsp_w;
  logic            r_rsp_f1;
  logic            r_rsp_f2;

  logic [15:0]     w_a   [N_REQ];
  logic [15:0]     w_b   [N_REQ];
  logic [2:0]      w_opc [N_REQ];
  logic            w_any;
  logic [IDW-1:0]  w_win;
  logic [IDW:0]    w_idx;
  logic [IDW-1:0]  w_rr_next;
  logic            w_grant;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign w_a[gi]   = i_req_a[16*gi +: 16];
      assign w_b[gi]   = i_req_b[16*gi +: 16];
      assign w_opc[gi] = i_req_opc[3*gi +: 3];
    end
  endgenerate

  // Walk downward in distance from rr_ptr so the nearest valid requester is the last one written.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      if (w_idx >= NREQ_W) begin
        w_idx = w_idx - NREQ_W;
      end
      if (i_req_valid[w_idx[IDW-1:0]] && !(PRIO_EN && (w_idx == '0))) begin
        w_any = 1'b1;
        w_win = w_idx[IDW-1:0];
      end
    end
    if (PRIO_EN && i_req_valid[0]) begin
      w_any = 1'b1;
      w_win = '0;
    end
  end

  always_comb begin
    w_rr_next = (r_grant_id == LAST_ID) ? '0 : r_grant_id + IDW'(1);
    if (PRIO_EN && (w_rr_next == '0)) begin
      w_rr_next = IDW'(1);
    end
  end

  assign w_grant = (r_state == S_IDLE) && w_any;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next_state = S_EXEC;
      S_EXEC:  w_next_state = S_RESP;
      S_RESP:  if (i_rsp_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Gated by reset so a requester never sees an accept while the block is held in reset.
  always_comb begin
    o_req_ready = '0;
    o_rsp_valid = (r_state == S_RESP);
    if (w_grant && i_rst_n) begin
      o_req_ready[w_win] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_cin  <= 1'b0;
      r_alu_opc  <= '0;
      r_rsp_id   <= '0;
      r_rsp_w    <= '0;
      r_rsp_f1   <= 1'b0;
      r_rsp_f2   <= 1'b0;
    end else begin
      if (w_grant) begin
        r_alu_a    <= w_a[w_win];
        r_alu_b    <= w_b[w_win];
        r_alu_cin  <= i_req_cin[w_win];
        r_alu_opc  <= w_opc[w_win];
        r_grant_id <= w_win;
      end
      if (r_state == S_EXEC) begin
        r_rsp_w  <= i_alu_w;
        r_rsp_f1 <= i_alu_f1;
        r_rsp_f2 <= i_alu_f2;
        r_rsp_id <= r_grant_id;
      end
      // The priority client is served outside the rotation, so it never moves the pointer.
      if ((r_state == S_RESP) && i_rsp_ready && !(PRIO_EN && (r_grant_id == '0))) begin
        r_rr_ptr <= w_rr_next;
      end
    end
  end

  assign o_alu_a   = r_alu_a;
  assign o_alu_b   = r_alu_b;
  assign o_alu_cin = r_alu_cin;
  assign o_alu_opc = r_alu_opc;
  assign o_rsp_id  = r_rsp_id;
  assign o_rsp_w   = r_rsp_w;
  assign o_rsp_f1  = r_rsp_f1;
  assign o_rsp_f2  = r_rsp_f2;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed and random bench for alu_rr_scheduler; a behavioural ALU closes the loop on the alu_* ports.
module tb_alu_rr_scheduler;
  localparam int N_REQ = 4;
  localparam int IDW   = 2;

  logic                clk;
  logic                rst_n;
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [16*N_REQ-1:0] req_a;
  logic [16*N_REQ-1:0] req_b;
  logic [N_REQ-1:0]    req_cin;
  logic [3*N_REQ-1:0]  req_opc;
  logic [15:0]         alu_a, alu_b, alu_w;
  logic                alu_cin, alu_f1, alu_f2;
  logic [2:0]          alu_opc;
  logic                rsp_valid, rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [15:0]         rsp_w;
  logic                rsp_f1, rsp_f2;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // {f2, f1, w} for the assumed external ALU: f1 = carry/borrow/shifted-out bit, f2 = zero result.
  function automatic logic [17:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic cin, input logic [2:0] opc);
    logic [16:0] r;
    case (opc)
      3'd0:    r = {1'b0, a} + {1'b0, b} + 17'(cin);
      3'd1:    r = {1'b0, a} - {1'b0, b} - 17'(cin);
      3'd2:    r = {1'b0, a & b};
      3'd3:    r = {1'b0, a | b};
      3'd4:    r = {1'b0, a ^ b};
      3'd5:    r = {a, 1'b0};
      3'd6:    r = {a[0], 1'b0, a[15:1]};
      default: r = {1'b0, ~a};
    endcase
    return {(r[15:0] == 16'h0000), r[16], r[15:0]};
  endfunction

  assign {alu_f2, alu_f1, alu_w} = alu_model(alu_a, alu_b, alu_cin, alu_opc);

  alu_rr_scheduler #(.N_REQ(N_REQ), .IDW(IDW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_a(req_a), .i_req_b(req_b), .i_req_cin(req_cin), .i_req_opc(req_opc),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_cin(alu_cin), .o_alu_opc(alu_opc),
    .i_alu_w(alu_w), .i_alu_f1(alu_f1), .i_alu_f2(alu_f2),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id),
    .o_rsp_w(rsp_w), .o_rsp_f1(rsp_f1), .o_rsp_f2(rsp_f2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic [2:0] opc);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
    req_cin[i]        = cin;
    req_opc[3*i +: 3] = opc;
  endtask

  task automatic reset_dut;
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_rsp(output int cycles, output bit timed_out);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!rsp_valid && cycles < 20);
    timed_out = !rsp_valid;
  endtask

  task automatic test_reset;
    bit saw_rsp;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if ({alu_a, alu_b, alu_cin, alu_opc, rsp_valid, rsp_id, rsp_w, rsp_f1, rsp_f2, req_ready} !== '0)
      $display("FAIL reset_state got a=%h b=%h rv=%b w=%h rdy=%b exp all zero", alu_a, alu_b, rsp_valid, rsp_w, req_ready);
    else pass_cnt++;
    rst_n = 1'b1;
    set_req(1, 16'h0005, 16'h0003, 1'b0, 3'd0);
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = '0;
    chk_cnt++;
    if ({alu_a, alu_b} !== {16'h0005, 16'h0003})
      $display("FAIL exec_load got a=%h b=%h exp a=0005 b=0003", alu_a, alu_b);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({alu_a, alu_b, alu_cin, alu_opc, rsp_valid, rsp_id, rsp_w, rsp_f1, rsp_f2, req_ready} !== '0)
      $display("FAIL reset_mid_exec got a=%h b=%h rv=%b w=%h exp all zero", alu_a, alu_b, rsp_valid, rsp_w);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    saw_rsp = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1'b1;
    end
    chk_cnt++;
    if (saw_rsp !== 1'b0) $display("FAIL reset_discard got rsp_valid=1 exp 0");
    else pass_cnt++;
  endtask

  task automatic test_single;
    @(negedge clk);
    rsp_ready = 1'b1;
    set_req(2, 16'h1234, 16'h1111, 1'b0, 3'd0);
    req_valid = 4'b0100;
    #1;
    chk_cnt++;
    if (req_ready !== 4'b0100) $display("FAIL single_ready got %b exp 0100", req_ready);
    else pass_cnt++;
    @(negedge clk);
    req_valid = '0;
    #1;
    chk_cnt++;
    if ({req_ready, rsp_valid} !== 5'b0) $display("FAIL single_exec got rdy=%b rv=%b exp 0000 0", req_ready, rsp_valid);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if ({rsp_valid, rsp_id, rsp_f2, rsp_f1, rsp_w} !== {1'b1, 2'd2, 18'h02345})
      $display("FAIL single_rsp got rv=%b id=%0d f2=%b f1=%b w=%h exp 1 2 0 0 2345", rsp_valid, rsp_id, rsp_f2, rsp_f1, rsp_w);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (rsp_valid !== 1'b0) $display("FAIL single_done got rv=%b exp 0", rsp_valid);
    else pass_cnt++;
  endtask

  task automatic test_rotation;
    logic [17:0] rot_exp [4];
    int cyc;
    bit to;
    rot_exp = '{18'h00101, 18'h00200, 18'h20000, 18'h00403};
    reset_dut();
    rsp_ready = 1'b1;
    for (int i = 0; i < N_REQ; i++)
      set_req(i, 16'h0101 + 16'(i) * 16'h0100, 16'(i), 1'b0, 3'(i));
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      wait_rsp(cyc, to);
      chk_cnt++;
      if (to || rsp_id !== IDW'(k % 4) || {rsp_f2, rsp_f1, rsp_w} !== rot_exp[k % 4])
        $display("FAIL rotation_%0d got to=%b id=%0d res=%h exp id=%0d res=%h", k, to, rsp_id,
                 {rsp_f2, rsp_f1, rsp_w}, k % 4, rot_exp[k % 4]);
      else pass_cnt++;
      if (k > 0) begin
        chk_cnt++;
        if (cyc !== 3) $display("FAIL rotation_gap_%0d got %0d cycles exp 3", k, cyc);
        else pass_cnt++;
      end
    end
    req_valid = '0;
  endtask

  task automatic test_prio;
    int cyc;
    bit to;
    reset_dut();
    rsp_ready = 1'b1;
    set_req(0, 16'h0010, 16'h0001, 1'b0, 3'd4);
    set_req(3, 16'h0020, 16'h0002, 1'b0, 3'd4);
    req_valid = 4'b1001;
    for (int n = 0; n < 5; n++) begin
      wait_rsp(cyc, to);
      chk_cnt++;
      if (to || rsp_id !== ((n < 4) ? 2'd0 : 2'd3))
        $display("FAIL prio_%0d got to=%b id=%0d exp %0d", n, to, rsp_id, (n < 4) ? 0 : 3);
      else pass_cnt++;
      if (n == 3) req_valid = 4'b1000;
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    rsp_ready = 1'b0;
    set_req(1, 16'hFFFF, 16'h0001, 1'b0, 3'd0);
    req_valid = 4'b0010;
    @(negedge clk);
    set_req(0, 16'h0001, 16'h0001, 1'b0, 3'd0);
    req_valid = 4'b0001;
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      chk_cnt++;
      if ({rsp_valid, rsp_id, rsp_f2, rsp_f1, rsp_w, req_ready} !== {1'b1, 2'd1, 18'h30000, 4'b0000})
        $display("FAIL bp_hold_%0d got rv=%b id=%0d f2=%b f1=%b w=%h rdy=%b exp 1 1 1 1 0000 0000", c,
                 rsp_valid, rsp_id, rsp_f2, rsp_f1, rsp_w, req_ready);
      else pass_cnt++;
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if ({rsp_valid, req_ready} !== 5'b0_0001)
      $display("FAIL bp_release got rv=%b rdy=%b exp 0 0001", rsp_valid, req_ready);
    else pass_cnt++;
    req_valid = '0;
  endtask

  task automatic test_random;
    int issued = 0, grants = 0, rsps = 0, cyc = 0, wi;
    bit done = 1'b0, exp_v = 1'b0;
    logic [IDW-1:0] exp_id;
    logic [17:0] exp_r;
    logic [N_REQ-1:0] gprev = '0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      req_valid = req_valid & ~gprev;
      rsp_ready = 1'($urandom_range(1));
      if (rsp_valid && rsp_ready) begin
        chk_cnt++;
        if (!exp_v || rsp_id !== exp_id || {rsp_f2, rsp_f1, rsp_w} !== exp_r)
          $display("FAIL rand_rsp got pend=%b id=%0d res=%h exp id=%0d res=%h", exp_v, rsp_id,
                   {rsp_f2, rsp_f1, rsp_w}, exp_id, exp_r);
        else pass_cnt++;
        exp_v = 1'b0;
        rsps++;
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (!req_valid[i] && issued < 1000 && $urandom_range(3) == 0) begin
          set_req(i, 16'($urandom), 16'($urandom), 1'($urandom_range(1)), 3'($urandom_range(7)));
          req_valid[i] = 1'b1;
          issued++;
        end
      end
      #1;
      gprev = req_ready;
      if (req_ready != '0) begin
        chk_cnt++;
        if (!$onehot(req_ready) || (req_ready & ~req_valid) != '0 || exp_v)
          $display("FAIL rand_grant got rdy=%b valid=%b pend=%b exp onehot subset idle", req_ready, req_valid, exp_v);
        else pass_cnt++;
        wi = 0;
        for (int i = 0; i < N_REQ; i++) if (req_ready[i]) wi = i;
        exp_id = IDW'(wi);
        exp_r  = alu_model(req_a[16*wi +: 16], req_b[16*wi +: 16], req_cin[wi], req_opc[3*wi +: 3]);
        exp_v  = 1'b1;
        grants++;
      end
      if (issued >= 1000 && grants == issued && !exp_v) done = 1'b1;
      if (cyc > 30000) begin
        $display("FAIL rand_timeout got %0d grants %0d rsps exp 1000", grants, rsps);
        done = 1'b1;
      end
    end
    chk_cnt++;
    if (grants !== 1000 || rsps !== 1000) $display("FAIL rand_count got g=%0d r=%0d exp 1000 1000", grants, rsps);
    else pass_cnt++;
    req_valid = '0;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    req_opc   = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_single();
`ifdef ALU_SCHED_PRIO_EN
    test_prio();
`else
    test_rotation();
`endif
    test_backpressure();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/alu_rr_scheduler.md
# alu_rr_scheduler

Round-robin scheduler that shares one combinational 16-bit ALU (operands a/b, carry-in, 3-bit opcode, 16-bit result, two flags) between N_REQ requesters. Sits in front of the ALU instance: it arbitrates incoming operation requests, registers the winner's operands onto the ALU inputs, captures the ALU result and flags, and returns them tagged with the requester index over a valid/ready response channel. One operation is in flight at a time.

## Interface
- N_REQ, 4: number of requesters (2..8).
- IDW, 2: requester-id width, equal to clog2(N_REQ).
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester request.
- req_ready  out  N_REQ  per-requester accept, one-hot or zero.
- req_a, req_b  in  16*N_REQ  operands; requester i in bits [16i+15:16i].
- req_cin  in  N_REQ  carry-in per requester.
- req_opc  in  3*N_REQ  opcode per requester.
- alu_a, alu_b  out  16  registered operands to ALU.
- alu_cin  out  1  registered carry-in to ALU.
- alu_opc  out  3  registered opcode to ALU.
- alu_w  in  16  ALU result (combinational from alu_* outputs).
- alu_f1, alu_f2  in  1  ALU flags.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  IDW  index of requester that issued the operation.
- rsp_w  out  16  captured result.
- rsp_f1, rsp_f2  out  1  captured flags.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state IDLE.
- IDLE: if any req_valid, winner = first set bit searching upward from rr_ptr, wrapping modulo N_REQ; req_ready[winner]=1 combinationally, all other req_ready=0. On the edge: load alu_a/b/cin/opc from winner, grant_id<=winner, go EXEC. No req_valid: stay IDLE, req_ready=0.
- EXEC: one cycle; ALU settles on registered operands. On edge: rsp_w<=alu_w, rsp_f1<=alu_f1, rsp_f2<=alu_f2, rsp_id<=grant_id, go RESP.
- RESP: rsp_valid=1; all outputs stable until rsp_valid&rsp_ready at an edge; then rr_ptr<=(grant_id+1) mod N_REQ, go IDLE.
- req_ready is 0 in EXEC and RESP; requests held by requesters wait.
- rr_ptr updates only on response completion, never on grant.
- alu_* outputs hold last loaded value outside IDLE-grant edges.
- Requester must hold req_valid and operands until req_ready; dropping req_valid before grant is legal and simply removes it from arbitration.

## Timing
- Reset (async assert, any state): state=IDLE, rr_ptr=0, grant_id=0, req_ready=0, alu_a=alu_b=0, alu_cin=0, alu_opc=0, rsp_valid=0, rsp_id=0, rsp_w=0, rsp_f1=rsp_f2=0. Reset mid-operation discards the in-flight op; no response is produced.
- Grant at edge E0; rsp_valid rises after E1 (latency 2 cycles request-accept to response-valid).
- rsp_ready already high: response completes at E2; next grant earliest at E3 (throughput one op per 3 cycles).
- rsp_ready low: RESP held indefinitely, no new grants.
- rsp_ready high in IDLE/EXEC: ignored.
- All requesters valid continuously: grants rotate 0,1,2,3,0,... with no requester served twice before the others.

## Configuration
- ALU_SCHED_PRIO_EN defined: requester 0 is fixed high priority; in IDLE, if req_valid[0]=1 it wins regardless of rr_ptr; otherwise round-robin among 1..N_REQ-1 from rr_ptr (rr_ptr skips 0). rr_ptr not updated when requester 0 completes.
- Not defined: pure round-robin over all requesters as in Operation.

## Test plan
- Reset mid-EXEC with req 1 granted (a=16'h0005, b=16'h0003) -> all outputs zero immediately, no rsp_valid after release, state IDLE.
- Single request req 2, a=16'h1234, b=16'h1111, cin=0, opc=3'd0, rsp_ready=1 -> req_ready=4'b0100 one cycle, rsp_valid 2 cycles later, rsp_id=2, rsp_w equals ALU model output for opc 0.
- All four req_valid held high, rsp_ready=1, 8 ops -> rsp_id sequence 0,1,2,3,0,1,2,3; one response every 3 cycles.
- Backpressure: rsp_ready=0 for 10 cycles during RESP -> rsp_valid, rsp_id, rsp_w, flags stable; req_ready=0 throughout; completion one edge after rsp_ready=1.
- ALU_SCHED_PRIO_EN defined, req 0 and req 3 valid continuously -> req 0 granted every time; req 3 never granted until req_valid[0] drops, then req 3 granted next IDLE.
- Random 1000 ops, random opcode/operands/rsp_ready per cycle -> every response matches behavioural ALU model for the issuing requester's operands; no grant lost or duplicated.
